// File: rtl/fib_seq_ctrl_if.sv
// Command, ALU and status signals of the Fibonacci sequencer, bundled so the
// lab top level and the ALU hookup see one connection point.
interface fib_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6,
  parameter int OP_W  = 3
) ();

  // Command side
  logic             start;
  logic             abort;
  logic             hold;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;

  // ALU side
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;

  // Status side
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;

  // The environment: issues commands and supplies the ALU result.
  modport master (
    output start, abort, hold, n, a0, b0, alu_y,
    input  alu_op, alu_a, alu_b, busy, done, result, ovf
  );

  // The sequencer itself.
  modport slave (
    input  start, abort, hold, n, a0, b0, alu_y,
    output alu_op, alu_a, alu_b, busy, done, result, ovf
  );

endinterface

// File: rtl/fib_seq_ctrl.sv
// Fibonacci-recurrence sequencer for the shared combinational ALU.
// Holds the two most recent terms, feeds them to the ALU with a fixed ADD
// opcode, and shifts the sum back in once per cycle until F(n) is reached.
module fib_seq_ctrl #(
  parameter int              WIDTH   = 8,
  parameter int              CNT_W   = 6,
  parameter int              OP_W    = 3,
  parameter logic [OP_W-1:0] ALU_ADD = 3'b000
) (
  input logic           clk,
  input logic           rst,
  fib_seq_ctrl_if.slave io_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_t1;       // current term F(k)
  logic [WIDTH-1:0] r_t2;       // next term F(k+1)
  logic [CNT_W-1:0] r_rem;      // additions still to perform
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;

  logic [WIDTH-1:0] w_t1_nxt;
  logic [WIDTH-1:0] w_t2_nxt;
  logic [CNT_W-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_ovf_nxt;
  logic             w_wrap;

  // An unsigned add wrapped iff the truncated sum is below one operand.
  assign w_wrap = (io_if.alu_y < r_t1);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: reset is asynchronous, so it sits in the sensitivity list and
  // clears state without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath-next logic; abort beats hold beats completion.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_t1_nxt     = r_t1;
    w_t2_nxt     = r_t2;
    w_rem_nxt    = r_rem;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;

    unique case (r_state)
      S_IDLE: begin
        if (io_if.start) begin
          w_t1_nxt    = io_if.a0;
          w_t2_nxt    = io_if.b0;
          w_rem_nxt   = io_if.n;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (io_if.abort) begin
          w_state_nxt = S_IDLE;
        end else if (io_if.hold) begin
          w_state_nxt = S_RUN;
        end else if (r_rem == '0) begin
          w_result_nxt = r_t1;
          w_state_nxt  = S_DONE;
        end else begin
          w_t1_nxt  = r_t2;
          w_t2_nxt  = io_if.alu_y;
          w_rem_nxt = r_rem - CNT_W'(1);
          // The add taken with one step left produces F(n+1), which is
          // thrown away, so its wrap must not taint the flag.
          if (w_wrap && (r_rem > CNT_W'(1))) w_ovf_nxt = 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t1     <= '0;
      r_t2     <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_t1     <= w_t1_nxt;
      r_t2     <= w_t2_nxt;
      r_rem    <= w_rem_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign io_if.alu_op = ALU_ADD;
  assign io_if.alu_a  = r_t1;
  assign io_if.alu_b  = r_t2;
  assign io_if.busy   = (r_state != S_IDLE);
  assign io_if.done   = (r_state == S_DONE);
  assign io_if.result = r_result;
  assign io_if.ovf    = r_ovf;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl: hand-computed Fibonacci results, latency,
// hold/abort/ignored-start behaviour and asynchronous reset.
module tb_fib_seq_ctrl;

  localparam int              WIDTH   = 8;
  localparam int              CNT_W   = 6;
  localparam int              OP_W    = 3;
  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;

  logic clk = 1'b0;
  logic rst;

  fib_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .OP_W(OP_W)) bus ();

  fib_seq_ctrl #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .OP_W(OP_W), .ALU_ADD(ALU_ADD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_if (bus)
  );

  // Clock, 10 ns period.
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU: modular add.
  assign bus.alu_y = bus.alu_a + bus.alu_b;

  int n_assert  = 0;
  int n_fail    = 0;
  int edge_cnt  = 0;   // edges since the edge that sampled start
  int done_cnt  = 0;   // done pulses seen over the whole run
  int busy_cnt  = 0;
  int op_bad    = 0;
  int done_snap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.alu_op !== ALU_ADD) op_bad++;
  endtask

  // Present a command for one edge; edge_cnt restarts at that sampling edge.
  task automatic issue(input logic [CNT_W-1:0] nn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start = 1'b1;
    bus.n     = nn;
    bus.a0    = a;
    bus.b0    = b;
    busy_cnt  = 0;
    step();
    bus.start = 1'b0;
    edge_cnt  = 0;
  endtask

  // Bounded wait for done; a timeout shows up as an edge-count/done failure.
  task automatic wait_done(input int max_edges);
    while (bus.done !== 1'b1 && edge_cnt < max_edges) step();
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    bus.n     = '0;
    bus.a0    = '0;
    bus.b0    = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ovf",    32'(bus.ovf),    32'd0);
    check("rst_alu_a",  32'(bus.alu_a),  32'd0);
    check("rst_alu_b",  32'(bus.alu_b),  32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));

    // 1: n=0 returns a0 after one edge
    op_bad = 0;
    issue(6'd0, 8'd3, 8'd5);
    check("t1_alu_a", 32'(bus.alu_a), 32'd3);
    check("t1_alu_b", 32'(bus.alu_b), 32'd5);
    wait_done(10);
    check("t1_done",   32'(bus.done),   32'd1);
    check("t1_edges",  32'(edge_cnt),   32'd1);
    check("t1_result", 32'(bus.result), 32'd3);
    check("t1_ovf",    32'(bus.ovf),    32'd0);
    step();
    check("t1_done_pulse", 32'(bus.done), 32'd0);
    check("t1_idle",       32'(bus.busy), 32'd0);
    check("t1_alu_op_all", 32'(op_bad),   32'd0);

    // 2: F10 from (0,1) = 55, busy for 12 cycles
    issue(6'd10, 8'd0, 8'd1);
    wait_done(20);
    check("t2_edges",  32'(edge_cnt),   32'd11);
    check("t2_result", 32'(bus.result), 32'd55);
    check("t2_ovf",    32'(bus.ovf),    32'd0);
    step();
    check("t2_idle",     32'(bus.busy), 32'd0);
    check("t2_busy_cyc", 32'(busy_cnt), 32'd12);

    // 3: F13 = 233 with masked F14 wrap, then F14 = 377 mod 256 = 121, ovf
    issue(6'd13, 8'd0, 8'd1);
    wait_done(20);
    check("t3a_edges",  32'(edge_cnt),   32'd14);
    check("t3a_result", 32'(bus.result), 32'd233);
    check("t3a_ovf",    32'(bus.ovf),    32'd0);
    // start offered during DONE must be ignored; it is taken from IDLE
    bus.start = 1'b1;
    bus.n     = 6'd14;
    step();
    check("t3_start_in_done", 32'(bus.busy), 32'd0);
    issue(6'd14, 8'd0, 8'd1);
    wait_done(20);
    check("t3b_edges",  32'(edge_cnt),   32'd15);
    check("t3b_result", 32'(bus.result), 32'd121);
    check("t3b_ovf",    32'(bus.ovf),    32'd1);
    step();

    // 4: n=5 from (2,3) = 21 with 3 hold cycles and a start re-pulse
    issue(6'd5, 8'd2, 8'd3);
    step();
    step();
    bus.hold  = 1'b1;
    bus.start = 1'b1;
    bus.n     = 6'd1;
    bus.a0    = 8'd7;
    bus.b0    = 8'd7;
    step();
    bus.start = 1'b0;
    step();
    step();
    check("t4_hold_a", 32'(bus.alu_a), 32'd5);
    check("t4_hold_b", 32'(bus.alu_b), 32'd8);
    bus.hold = 1'b0;
    wait_done(20);
    check("t4_edges",  32'(edge_cnt),   32'd9);
    check("t4_result", 32'(bus.result), 32'd21);
    step();
    check("t4_idle", 32'(bus.busy), 32'd0);

    // 5: abort after 4 RUN edges (with hold also high), result keeps 21
    issue(6'd20, 8'd0, 8'd1);
    done_snap = done_cnt;
    step();
    step();
    step();
    step();
    bus.abort = 1'b1;
    bus.hold  = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    check("t5_abort_idle", 32'(bus.busy), 32'd0);
    step();
    step();
    check("t5_no_done", 32'(done_cnt),   32'(done_snap));
    check("t5_result",  32'(bus.result), 32'd21);
    check("t5_ovf",     32'(bus.ovf),    32'd0);
    issue(6'd2, 8'd1, 8'd1);
    wait_done(10);
    check("t5_edges",  32'(edge_cnt),   32'd3);
    check("t5_result2", 32'(bus.result), 32'd2);
    step();

    // 6: asynchronous reset mid-run after ovf has been set
    issue(6'd20, 8'd0, 8'd1);
    for (int i = 0; i < 16; i++) step();
    check("t6_pre_ovf",  32'(bus.ovf),  32'd1);
    check("t6_pre_busy", 32'(bus.busy), 32'd1);
    done_snap = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check("t6_busy",   32'(bus.busy),   32'd0);
    check("t6_done",   32'(bus.done),   32'd0);
    check("t6_result", 32'(bus.result), 32'd0);
    check("t6_ovf",    32'(bus.ovf),    32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("t6_no_done", 32'(done_cnt), 32'(done_snap));
    issue(6'd1, 8'd4, 8'd9);
    wait_done(10);
    check("t6_edges",  32'(edge_cnt),   32'd2);
    check("t6_result2", 32'(bus.result), 32'd9);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
